decode_stage: RTL and testbench

Registered, flow-controlled successor to the combinational RV32I instruction decoder. It sits between fetch and execute and accepts one instruction per cycle over a valid/ready handshake. Output is a fully decoded micro-op bundle with strict illegal-instruction detection, optional M-extension and Zicsr decode, a 2-entry skid buffer for full-throughput backpressure, flush support, and a saturating illegal-instruction counter.

---
 rtl/decode_pkg.sv | 78 +++++++
 rtl/decode_comb.sv | 150 +++++++++++++++
 rtl/decode_stage.sv | 117 +++++++++++
 tb/tb_decode_stage.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// ----------------------------------------------------------------------------
// decode_pkg: shared RV32I decode types, opcodes and helpers | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package decode_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

  typedef enum logic [3:0] {
    CLS_ALU, CLS_MUL, CLS_DIV, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL,
    CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_FENCE, CLS_CSR, CLS_SYS, CLS_ILLEGAL
  } cls_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {
    FMT_NONE, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
  } imm_fmt_e;

  // imm is sized for the widest XLEN; bits above the configured XLEN stay zero
  typedef struct packed {
    cls_e                cls;
    alu_op_e             alu_op;
    logic [2:0]          funct3;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                rs1_used;
    logic                rs2_used;
    logic                wr_en;
    logic [XLEN_MAX-1:0] imm;
    logic                illegal;
  } decoded_t;

  function automatic logic [XLEN_MAX-1:0] ext_imm(input logic [31:0] v, input int xlen);
    return (xlen == 64) ? {{32{v[31]}}, v} : {32'b0, v};
  endfunction

  function automatic alu_op_e alu_base(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_comb.sv
// ----------------------------------------------------------------------------
// decode_comb: combinational RV32I(+M, Zicsr) decoder with strict legality | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit EN_M     = 1'b1,
  parameter bit EN_ZICSR = 1'b1
) (
  input  logic [31:0] instr_i,
  output decoded_t    uop_o
);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  imm_fmt_e   w_fmt;
  cls_e       w_cls;
  alu_op_e    w_alu;
  logic       w_bad;
  logic       w_wr;
  logic       w_r1;
  logic       w_r2;
  logic [31:0] w_imm32;

  assign w_opc = instr_i[6:0];
  assign w_f3  = instr_i[14:12];
  assign w_f7  = instr_i[31:25];

  always_comb begin
    w_fmt = FMT_NONE;
    w_cls = CLS_ILLEGAL;
    w_alu = ALU_ADD;
    w_bad = 1'b0;
    w_wr  = 1'b0;
    w_r1  = 1'b0;
    w_r2  = 1'b0;
    if (instr_i[1:0] != 2'b11) begin
      w_bad = 1'b1;
    end else begin
      case (w_opc)
        OPC_LOAD: begin
          w_bad = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
          w_cls = CLS_LOAD; w_fmt = FMT_I; w_r1 = 1'b1; w_wr = 1'b1;
        end
        OPC_STORE: begin
          w_bad = (w_f3 > 3'b010);
          w_cls = CLS_STORE; w_fmt = FMT_S; w_r1 = 1'b1; w_r2 = 1'b1;
        end
        OPC_BRANCH: begin
          w_bad = (w_f3[2:1] == 2'b01);
          w_cls = CLS_BRANCH; w_fmt = FMT_B; w_r1 = 1'b1; w_r2 = 1'b1;
        end
        OPC_MISC_MEM: begin
          w_bad = (w_f3[2:1] != 2'b00);
          w_cls = CLS_FENCE;
        end
        OPC_OP_IMM: begin
          w_cls = CLS_ALU; w_fmt = FMT_I; w_r1 = 1'b1; w_wr = 1'b1;
          w_alu = alu_base(w_f3);
          if (w_f3 == 3'b001) begin
            w_fmt = FMT_SH;
            w_bad = (w_f7 != F7_BASE);
          end else if (w_f3 == 3'b101) begin
            w_fmt = FMT_SH;
            if (w_f7 == F7_ALT) w_alu = ALU_SRA;
            else                w_bad = (w_f7 != F7_BASE);
          end
        end
        OPC_OP: begin
          w_r1 = 1'b1; w_r2 = 1'b1; w_wr = 1'b1; w_cls = CLS_ALU;
          if (w_f7 == F7_MULDIV) begin
            w_bad = !EN_M;
            w_cls = w_f3[2] ? CLS_DIV : CLS_MUL;
          end else if (w_f7 == F7_BASE) begin
            w_alu = alu_base(w_f3);
          end else if (w_f7 == F7_ALT) begin
            case (w_f3)
              3'b000:  w_alu = ALU_SUB;
              3'b101:  w_alu = ALU_SRA;
              default: w_bad = 1'b1;
            endcase
          end else begin
            w_bad = 1'b1;
          end
        end
        OPC_LUI:   begin w_cls = CLS_LUI;   w_fmt = FMT_U; w_wr = 1'b1; end
        OPC_AUIPC: begin w_cls = CLS_AUIPC; w_fmt = FMT_U; w_wr = 1'b1; end
        OPC_JAL:   begin w_cls = CLS_JAL;   w_fmt = FMT_J; w_wr = 1'b1; end
        OPC_JALR: begin
          w_bad = (w_f3 != 3'b000);
          w_cls = CLS_JALR; w_fmt = FMT_I; w_r1 = 1'b1; w_wr = 1'b1;
        end
        OPC_SYSTEM: begin
          if (w_f3 == 3'b000) begin
            w_cls = CLS_SYS;
            w_bad = !((instr_i == INSTR_ECALL) || (instr_i == INSTR_EBREAK) ||
                      (instr_i == INSTR_MRET));
          end else if (w_f3 == 3'b100) begin
            w_bad = 1'b1;
          end else begin
            // immediate CSR forms carry a uimm in the rs1 field, not a register
            w_cls = CLS_CSR; w_fmt = FMT_I; w_wr = 1'b1; w_r1 = !w_f3[2];
            w_bad = !EN_ZICSR;
          end
        end
        default: w_bad = 1'b1;
      endcase
    end
  end

  always_comb begin
    case (w_fmt)
      FMT_I:   w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_SH:  w_imm32 = {27'b0, instr_i[24:20]};
      FMT_S:   w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B:   w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                          instr_i[11:8], 1'b0};
      FMT_U:   w_imm32 = {instr_i[31:12], 12'b0};
      FMT_J:   w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                          instr_i[30:21], 1'b0};
      default: w_imm32 = 32'b0;
    endcase
  end

  always_comb begin
    uop_o        = '0;
    uop_o.funct3 = w_f3;
    uop_o.rd     = instr_i[11:7];
    uop_o.rs1    = instr_i[19:15];
    uop_o.rs2    = instr_i[24:20];
    if (w_bad) begin
      uop_o.cls     = CLS_ILLEGAL;
      uop_o.illegal = 1'b1;
    end else begin
      uop_o.cls      = w_cls;
      uop_o.alu_op   = w_alu;
      uop_o.rs1_used = w_r1;
      uop_o.rs2_used = w_r2;
      uop_o.wr_en    = w_wr && (instr_i[11:7] != 5'd0);
      uop_o.imm      = ext_imm(w_imm32, XLEN);
    end
  end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage: registered decode with 2-entry skid buffer and illegal counter | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit EN_M     = 1'b1,
  parameter bit EN_ZICSR = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output decoded_t         out_uop,
  output logic [CNT_W-1:0] illegal_cnt
);

  decoded_t w_dec;

  decode_comb #(
    .XLEN     (XLEN),
    .EN_M     (EN_M),
    .EN_ZICSR (EN_ZICSR)
  ) u_decode_comb (
    .instr_i (in_instr),
    .uop_o   (w_dec)
  );

  logic             m_valid_q, m_valid_d;
  logic [XLEN-1:0]  m_pc_q,    m_pc_d;
  decoded_t         m_uop_q,   m_uop_d;
  logic             s_valid_q, s_valid_d;
  logic [XLEN-1:0]  s_pc_q,    s_pc_d;
  decoded_t         s_uop_q,   s_uop_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  logic w_in_xfer;
  logic w_out_xfer;

  assign w_in_xfer  = in_valid && !s_valid_q;
  assign w_out_xfer = m_valid_q && out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_pc_d    = m_pc_q;
    m_uop_d   = m_uop_q;
    s_valid_d = s_valid_q;
    s_pc_d    = s_pc_q;
    s_uop_d   = s_uop_q;
    cnt_d     = cnt_q;
    // a flush cycle drops the op sitting in M, so it is neither delivered nor counted
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else begin
      if (w_out_xfer && m_uop_q.illegal && (cnt_q != {CNT_W{1'b1}}))
        cnt_d = cnt_q + 1'b1;
      if (!m_valid_q || out_ready) begin
        if (s_valid_q) begin
          m_valid_d = 1'b1;
          m_pc_d    = s_pc_q;
          m_uop_d   = s_uop_q;
          s_valid_d = 1'b0;
        end else if (w_in_xfer) begin
          m_valid_d = 1'b1;
          m_pc_d    = in_pc;
          m_uop_d   = w_dec;
        end else begin
          m_valid_d = 1'b0;
        end
      end else if (w_in_xfer) begin
        s_valid_d = 1'b1;
        s_pc_d    = in_pc;
        s_uop_d   = w_dec;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_pc_q    <= '0;
      m_uop_q   <= '0;
      s_valid_q <= 1'b0;
      s_pc_q    <= '0;
      s_uop_q   <= '0;
      cnt_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_pc_q    <= m_pc_d;
      m_uop_q   <= m_uop_d;
      s_valid_q <= s_valid_d;
      s_pc_q    <= s_pc_d;
      s_uop_q   <= s_uop_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready    = !s_valid_q;
  assign out_valid   = m_valid_q;
  assign out_pc      = m_pc_q;
  assign out_uop     = m_uop_q;
  assign illegal_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_decode_stage: randomized bench against a queue-based reference model | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready,  in_ready_nm;
  logic        out_valid, out_valid_nm;
  logic [31:0] out_pc,    out_pc_nm;
  decoded_t    out_uop,   out_uop_nm;
  logic [15:0] cnt;
  logic [1:0]  cnt_nm;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .EN_M(1'b1), .EN_ZICSR(1'b1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_uop(out_uop), .illegal_cnt(cnt)
  );

  decode_stage #(.XLEN(32), .EN_M(1'b0), .EN_ZICSR(1'b1), .CNT_W(2)) u_dut_nm (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_nm),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_nm), .out_ready(out_ready),
    .out_pc(out_pc_nm), .out_uop(out_uop_nm), .illegal_cnt(cnt_nm)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: up to two instructions in flight, oldest presented downstream.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  ent_t q[$];
  int   m_cnt  = 0;
  int   nm_cnt = 0;

  function automatic decoded_t ref_decode(input logic [31:0] w, input bit en_m);
    decoded_t   u;
    logic [2:0] f3  = w[14:12];
    logic [6:0] f7  = w[31:25];
    bit         ok  = 1'b1;
    bit         rdw = 1'b0, r1 = 1'b0, r2 = 1'b0;
    cls_e       c   = CLS_ILLEGAL;
    alu_op_e    a   = ALU_ADD;
    byte        fmt = "N";
    int         simm = 0;
    alu_op_e    tab[8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    if (w[1:0] != 2'b11) ok = 1'b0;
    else begin
      case (w[6:0])
        OPC_LOAD:     begin c = CLS_LOAD; fmt = "I"; r1 = 1; rdw = 1;
                            ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); end
        OPC_STORE:    begin c = CLS_STORE; fmt = "S"; r1 = 1; r2 = 1; ok = (f3 <= 3'd2); end
        OPC_BRANCH:   begin c = CLS_BRANCH; fmt = "B"; r1 = 1; r2 = 1;
                            ok = !(f3 inside {3'd2, 3'd3}); end
        OPC_MISC_MEM: begin c = CLS_FENCE; ok = (f3 <= 3'd1); end
        OPC_LUI:      begin c = CLS_LUI; fmt = "U"; rdw = 1; end
        OPC_AUIPC:    begin c = CLS_AUIPC; fmt = "U"; rdw = 1; end
        OPC_JAL:      begin c = CLS_JAL; fmt = "J"; rdw = 1; end
        OPC_JALR:     begin c = CLS_JALR; fmt = "I"; r1 = 1; rdw = 1; ok = (f3 == 3'd0); end
        OPC_OP_IMM: begin
          c = CLS_ALU; r1 = 1; rdw = 1; fmt = "I"; a = tab[f3];
          if (f3 == 3'd1) begin fmt = "H"; ok = (f7 == 7'h00); end
          if (f3 == 3'd5) begin
            fmt = "H";
            if (f7 == 7'h20) a = ALU_SRA;
            else ok = (f7 == 7'h00);
          end
        end
        OPC_OP: begin
          c = CLS_ALU; r1 = 1; r2 = 1; rdw = 1;
          if (f7 == 7'h01) begin ok = en_m; c = (f3 >= 3'd4) ? CLS_DIV : CLS_MUL; end
          else if (f7 == 7'h00) a = tab[f3];
          else if (f7 == 7'h20 && f3 == 3'd0) a = ALU_SUB;
          else if (f7 == 7'h20 && f3 == 3'd5) a = ALU_SRA;
          else ok = 1'b0;
        end
        OPC_SYSTEM: begin
          if (f3 == 3'd0) begin
            c = CLS_SYS;
            ok = (w == 32'h0000_0073) || (w == 32'h0010_0073) || (w == 32'h3020_0073);
          end else if (f3 == 3'd4) ok = 1'b0;
          else begin c = CLS_CSR; fmt = "I"; rdw = 1; r1 = (f3 < 3'd4); end
        end
        default: ok = 1'b0;
      endcase
    end
    case (fmt)
      "I": simm = $signed(w) >>> 20;
      "H": simm = int'(w[24:20]);
      "S": simm = ($signed(w) >>> 25) * 32 + int'(w[11:7]);
      "B": simm = ($signed(w) >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                  + int'(w[11:8]) * 2;
      "U": simm = int'({w[31:12], 12'b0});
      "J": simm = ($signed(w) >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                  + int'(w[30:21]) * 2;
      default: simm = 0;
    endcase
    u        = '0;
    u.funct3 = f3;
    u.rd     = w[11:7];
    u.rs1    = w[19:15];
    u.rs2    = w[24:20];
    if (!ok) begin
      u.cls     = CLS_ILLEGAL;
      u.illegal = 1'b1;
    end else begin
      u.cls      = c;
      u.alu_op   = a;
      u.rs1_used = r1;
      u.rs2_used = r2;
      u.wr_en    = rdw && (w[11:7] != 5'd0);
      u.imm      = {32'b0, 32'(simm)};
    end
    return u;
  endfunction

  task automatic compare_model();
    bit ev = (q.size() > 0);
    chk("out_valid", out_valid, ev);
    chk("out_valid_nm", out_valid_nm, ev);
    chk("in_ready", in_ready, q.size() < 2);
    chk("in_ready_nm", in_ready_nm, q.size() < 2);
    if (ev) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_uop", out_uop, ref_decode(q[0].instr, 1'b1));
      chk("out_pc_nm", out_pc_nm, q[0].pc);
      chk("out_uop_nm", out_uop_nm, ref_decode(q[0].instr, 1'b0));
    end
    chk("illegal_cnt", cnt, m_cnt);
    chk("illegal_cnt_nm", cnt_nm, nm_cnt);
  endtask

  task automatic model_update();
    bit   rdy = (q.size() < 2);
    ent_t e;
    if (flush) q.delete();
    else begin
      if (q.size() > 0 && out_ready) begin
        e = q.pop_front();
        if (ref_decode(e.instr, 1'b1).illegal && m_cnt < 65535) m_cnt++;
        if (ref_decode(e.instr, 1'b0).illegal && nm_cnt < 3) nm_cnt++;
      end
      if (in_valid && rdy) begin
        e.instr = in_instr;
        e.pc    = in_pc;
        q.push_back(e);
      end
    end
  endtask

  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit ordy, input bit fl);
    @(negedge clk);
    compare_model();
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_update();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    logic [6:0]  opcs[11] = '{OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_MISC_MEM, OPC_OP_IMM,
                              OPC_AUIPC, OPC_OP, OPC_LUI, OPC_JALR, OPC_JAL, OPC_SYSTEM};
    logic [31:0] sys[3] = '{32'h0000_0073, 32'h0010_0073, 32'h3020_0073};
    int k = $urandom_range(0, 19);
    if (k < 16) w[6:0] = opcs[k % 11];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    if ($urandom_range(0, 15) == 0) w = sys[$urandom_range(0, 2)];
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int saved;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_cnt", cnt, 16'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_uop", out_uop, '0);
    @(negedge clk);
    rst = 1'b0;

    // addi then mul, back-to-back
    step(1, 32'h0050_0093, 32'h100, 1, 0);
    #1;
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_cls", out_uop.cls, CLS_ALU);
    chk("addi_imm", out_uop.imm, 64'd5);
    chk("addi_wr", out_uop.wr_en, 1'b1);
    step(1, 32'h0220_81B3, 32'h104, 1, 0);
    #1;
    chk("mul_cls", out_uop.cls, CLS_MUL);
    chk("mul_rs1", out_uop.rs1, 5'd1);
    chk("mul_rs2", out_uop.rs2, 5'd2);
    chk("nm_mul_illegal", out_uop_nm.illegal, 1'b1);
    chk("nm_mul_wr", out_uop_nm.wr_en, 1'b0);
    step(1, 32'h6010_D093, 32'h108, 1, 0);
    #1;
    chk("nm_cnt_1", cnt_nm, 2'd1);
    step(0, 32'h0, 32'h0, 1, 0);
    #1;
    chk("nm_cnt_2", cnt_nm, 2'd2);
    chk("cnt_srai", cnt, 16'd1);

    // immediates and rd==0
    step(1, 32'h0000_0013, 32'h200, 1, 0);
    #1;
    chk("nop_wr", out_uop.wr_en, 1'b0);
    step(1, 32'hFFF0_0093, 32'h204, 1, 0);
    #1;
    chk("imm_m1", out_uop.imm, 64'h0000_0000_FFFF_FFFF);
    step(1, 32'hFE00_0EE3, 32'h208, 1, 0);
    #1;
    chk("beq_imm", out_uop.imm, 64'h0000_0000_FFFF_FFFC);
    step(0, 32'h0, 32'h0, 1, 0);

    // backpressure: 3 stalled cycles with continuous offers
    step(1, 32'h0010_0113, 32'h300, 0, 0);
    step(1, 32'h0020_0193, 32'h304, 0, 0);
    #1;
    chk("bp_ready_low", in_ready, 1'b0);
    step(1, 32'h0030_0213, 32'h308, 0, 0);
    #1;
    chk("bp_held_pc", out_pc, 32'h300);
    for (int i = 0; i < 4; i++) step(1, 32'h0040_0293 + (i << 20), 32'h30C + 4 * i, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);

    // flush with both entries full and a concurrent offer
    step(1, 32'h0000_0000, 32'h400, 0, 0);
    step(1, 32'h0000_0000, 32'h404, 0, 0);
    saved = m_cnt;
    step(1, 32'h0000_0000, 32'h408, 0, 1);
    #1;
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    chk("flush_cnt", cnt, 16'(saved));

    // saturation of the narrow counter
    for (int i = 0; i < 5; i++) step(1, 32'hFFFF_FFFF, 32'h500 + 4 * i, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    #1;
    chk("nm_cnt_sat", cnt_nm, 2'd3);

    // asynchronous reset mid-stream
    step(1, 32'h0000_0000, 32'h600, 0, 0);
    step(1, 32'h0000_0000, 32'h604, 0, 0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_ready", in_ready, 1'b1);
    chk("arst_cnt", cnt, 16'd0);
    chk("arst_cnt_nm", cnt_nm, 2'd0);
    q.delete();
    m_cnt  = 0;
    nm_cnt = 0;
    #1 rst = 1'b0;
    @(posedge clk);
    model_update();

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    step(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    compare_model();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
